alu_sched: RTL and testbench

Round-robin scheduler that shares one combinational `alu` instance between NREQ requesters using valid/ready handshakes. It captures one requester's operands and holds them stable on the ALU inputs for a per-opcode number of cycles, treating multiply and divide/modulo as multicycle paths. It then registers the result and returns it, tagged with the requester index, on a response channel. It sits between the pipeline issue stages and the single shared ALU.

---
 rtl/alu_sched.sv | 148 ++++++++++++++
 tb/tb_alu_sched.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sched.sv
// Round-robin scheduler sharing one combinational ALU among NREQ requesters,
// holding operands for per-opcode multicycle paths. Option: ALU_SCHED_DIVZERO_EN.
module alu_sched #(
  parameter int NREQ       = 2,
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4,
  localparam int IDW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*3-1:0]     req_sel,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_sel,
  input  logic [WIDTH-1:0]      alu_c,
  input  logic                  alu_z,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_c,
  output logic                  rsp_z,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int MAXL = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t           state, state_nx;
  logic [IDW-1:0]   last, gnt_id, cand;
  logic             gnt_any, fire;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_arr [NREQ];
  logic [WIDTH-1:0] b_arr [NREQ];
  logic [2:0]       s_arr [NREQ];
  logic [WIDTH-1:0] in_a, in_b;
  logic [2:0]       in_sel;
  logic             dz_in, dz;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    assign s_arr[i] = req_sel[i*3 +: 3];
  end

  // Search starts one past the last winner so a busy set rotates strictly.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    cand    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last) + k) % NREQ);
      if (!gnt_any && req_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && gnt_any) req_ready[gnt_id] = 1'b1;
  end

  assign fire   = (state == IDLE) && gnt_any;
  assign in_a   = a_arr[gnt_id];
  assign in_b   = b_arr[gnt_id];
  assign in_sel = s_arr[gnt_id];
  assign busy   = (state != IDLE);

`ifdef ALU_SCHED_DIVZERO_EN
  assign dz_in = (in_sel == 3'b011 || in_sel == 3'b100) && (in_b == '0);
  assign dz    = (alu_sel == 3'b011 || alu_sel == 3'b100) && (alu_b == '0);
`else
  assign dz_in = 1'b0;
  assign dz    = 1'b0;
`endif

  function automatic logic [CW-1:0] lat_m1(input logic [2:0] s);
    case (s)
      3'b010:         return CW'(MUL_CYCLES - 1);
      3'b011, 3'b100: return CW'(DIV_CYCLES - 1);
      default:        return '0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any)      state_nx = EXEC;
      EXEC:    if (cnt == '0)    state_nx = RESP;
      RESP:    if (rsp_ready)    state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  // Operand registers feed the ALU directly, so its inputs cannot glitch mid-op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      cnt       <= '0;
      last      <= IDW'(NREQ - 1);
      rsp_valid <= 1'b0;
      rsp_c     <= '0;
      rsp_z     <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_id    <= '0;
    end else begin
      case (state)
        IDLE: if (fire) begin
          alu_a   <= in_a;
          alu_b   <= in_b;
          alu_sel <= in_sel;
          last    <= gnt_id;
          cnt     <= dz_in ? '0 : lat_m1(in_sel);
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_valid <= 1'b1;
            rsp_id    <= last;
            rsp_c     <= dz ? '1 : alu_c;
            rsp_z     <= dz ? 1'b0 : alu_z;
            rsp_err   <= dz;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Scoreboard bench for alu_sched: NREQ=2, WIDTH=32, MUL=2, DIV=4, with a behavioural ALU.
module tb_alu_sched;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req_valid = '0;
  logic [1:0]       req_ready;
  logic [1:0][31:0] ra = '0, rb = '0;
  logic [1:0][2:0]  rs = '0;
  logic [31:0]      alu_a, alu_b, alu_c, rsp_c;
  logic [2:0]       alu_sel;
  logic             alu_z, rsp_valid, rsp_z, rsp_err, busy;
  logic             rsp_ready = 1'b1;
  logic [0:0]       rsp_id;

  int vectors = 0, miscompares = 0, cyc = 0;
  bit seen = 0;

  typedef struct {
    logic [0:0]  id;
    logic [31:0] a, b, c;
    logic [2:0]  sel;
    logic        z, err;
    int          lat, acc;
  } entry_t;
  entry_t q[$];

  always #5 clk = ~clk;

  alu_sched #(.NREQ(2), .WIDTH(32), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(ra), .req_b(rb), .req_sel(rs),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_c(alu_c), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_err(rsp_err), .busy(busy)
  );

  // Shared ALU stand-in; division by zero yields a recognisable marker.
  always_comb begin
    alu_c = alu_a + alu_b;
    case (alu_sel)
      3'b001: alu_c = alu_a - alu_b;
      3'b010: alu_c = alu_a * alu_b;
      3'b011: alu_c = (alu_b == 0) ? 32'hDEADBEEF : alu_a / alu_b;
      3'b100: alu_c = (alu_b == 0) ? 32'hDEADBEEF : alu_a % alu_b;
      default: ;
    endcase
    alu_z = (alu_c == 32'd0);
  end

  function automatic void expect_op(input logic [2:0] s, input logic [31:0] a, b,
                                    output logic [31:0] c, output logic z, err, output int lat);
    err = 1'b0;
    lat = 1;
    case (s)
      3'b001: c = a - b;
      3'b010: begin c = a * b; lat = 2; end
      3'b011: begin c = (b == 0) ? 32'hDEADBEEF : a / b; lat = 4; end
      3'b100: begin c = (b == 0) ? 32'hDEADBEEF : a % b; lat = 4; end
      default: c = a + b;
    endcase
`ifdef ALU_SCHED_DIVZERO_EN
    if ((s == 3'b011 || s == 3'b100) && b == 0) begin c = '1; lat = 1; err = 1'b1; end
`endif
    z = (c == 32'd0);
  endfunction

  // One clock: record handshakes, check held operands and responses at negedge.
  task automatic tick();
    entry_t e;
    int id;
    @(negedge clk);
    if (!rst && (req_valid & req_ready) != 2'b00) begin
      id = req_ready[1] ? 1 : 0;
      e.id = id[0]; e.a = ra[id]; e.b = rb[id]; e.sel = rs[id]; e.acc = cyc;
      expect_op(e.sel, e.a, e.b, e.c, e.z, e.err, e.lat);
      q.push_back(e);
    end
    if (busy && !rsp_valid && q.size() > 0) begin
      vectors++;
      if ({alu_a, alu_b, alu_sel} !== {q[0].a, q[0].b, q[0].sel}) begin
        miscompares++;
        $display("FAIL alu_hold got=%h/%h/%h exp=%h/%h/%h", alu_a, alu_b, alu_sel, q[0].a, q[0].b, q[0].sel);
      end
    end
    if (rsp_valid) begin
      if (q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_rsp got id=%0d c=%h exp no response", rsp_id, rsp_c);
      end else begin
        if (!seen) begin
          seen = 1;
          vectors++;
          if (cyc - q[0].acc !== q[0].lat + 1) begin
            miscompares++;
            $display("FAIL latency got=%0d exp=%0d", cyc - q[0].acc - 1, q[0].lat);
          end
        end
        vectors++;
        if ({rsp_id, rsp_c, rsp_z, rsp_err} !== {q[0].id, q[0].c, q[0].z, q[0].err}) begin
          miscompares++;
          $display("FAIL rsp got id=%0d c=%h z=%b e=%b exp id=%0d c=%h z=%b e=%b",
                   rsp_id, rsp_c, rsp_z, rsp_err, q[0].id, q[0].c, q[0].z, q[0].err);
        end
        if (rsp_ready) begin void'(q.pop_front()); seen = 0; end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 20 && !rsp_valid; i++) tick();
    vectors++;
    if (!rsp_valid) begin miscompares++; $display("FAIL rsp_timeout got rsp_valid=0 exp 1"); end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (q.size() != 0 || busy); i++) tick();
    vectors++;
    if (q.size() != 0 || busy) begin
      miscompares++;
      $display("FAIL drain_timeout got pending=%0d busy=%b exp 0/0", q.size(), busy);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({req_ready, rsp_valid, rsp_c, rsp_z, rsp_err, rsp_id, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got rdy=%b v=%b c=%h z=%b e=%b id=%0d busy=%b exp all 0",
               req_ready, rsp_valid, rsp_c, rsp_z, rsp_err, rsp_id, busy);
    end
    vectors++;
    if ({alu_a, alu_b, alu_sel} !== '0) begin
      miscompares++;
      $display("FAIL reset_alu got %h/%h/%h exp 0", alu_a, alu_b, alu_sel);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_round_robin();
    int g[4];
    int n = 0;
    ra[0] = 9; rb[0] = 9; rs[0] = 3'b001;
    ra[1] = 6; rb[1] = 7; rs[1] = 3'b010;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    #1;
    for (int i = 0; i < 40 && n < 4; i++) begin
      if (req_ready != 2'b00) begin g[n] = req_ready[1] ? 1 : 0; n++; end
      if (n < 4) tick();
    end
    tick();
    req_valid = 2'b00;
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL rr_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      vectors++;
      if (g[i] !== i % 2) begin miscompares++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", i, g[i], i % 2); end
    end
    drain();
  endtask

  task automatic test_add();
    ra[0] = 5; rb[0] = 7; rs[0] = 3'b000;
    req_valid = 2'b01;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL add_grant got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    wait_rsp();
    vectors++;
    if ({rsp_c, rsp_z, rsp_id} !== {32'd12, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL add_rsp got c=%0d z=%b id=%0d exp 12/0/0", rsp_c, rsp_z, rsp_id);
    end
    drain();
  endtask

  task automatic test_div_mod();
    ra[1] = 100; rb[1] = 7; rs[1] = 3'b011;
    req_valid = 2'b10;
    tick();
    req_valid = 2'b00;
    wait_rsp();
    vectors++;
    if ({rsp_c, rsp_id} !== {32'd14, 1'b1}) begin
      miscompares++; $display("FAIL div_rsp got c=%0d id=%0d exp 14/1", rsp_c, rsp_id);
    end
    drain();
    ra[0] = 100; rb[0] = 7; rs[0] = 3'b100;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_rsp();
    vectors++;
    if ({rsp_c, rsp_id} !== {32'd2, 1'b0}) begin
      miscompares++; $display("FAIL mod_rsp got c=%0d id=%0d exp 2/0", rsp_c, rsp_id);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    rsp_ready = 1'b0;
    ra[0] = 1; rb[0] = 2; rs[0] = 3'b000;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    wait_rsp();
    ra[1] = 10; rb[1] = 3; rs[1] = 3'b001;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if ({rsp_valid, rsp_c, rsp_id, req_ready} !== {1'b1, 32'd3, 1'b0, 2'b00}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d] got v=%b c=%0d id=%0d rdy=%b exp 1/3/0/00", i, rsp_valid, rsp_c, rsp_id, req_ready);
      end
    end
    rsp_ready = 1'b1;
    tick();
    vectors++;
    if (req_ready !== 2'b10) begin miscompares++; $display("FAIL bp_next_grant got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    drain();
  endtask

  task automatic test_div_zero();
    int waited = 0;
    ra[0] = 8; rb[0] = 0; rs[0] = 3'b011;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    for (int i = 0; i < 20 && !rsp_valid; i++) begin tick(); waited++; end
    vectors++;
`ifdef ALU_SCHED_DIVZERO_EN
    if ({waited[3:0], rsp_c, rsp_err} !== {4'd1, 32'hFFFFFFFF, 1'b1}) begin
      miscompares++;
      $display("FAIL divzero got wait=%0d c=%h e=%b exp 1/ffffffff/1", waited, rsp_c, rsp_err);
    end
`else
    if ({waited[3:0], rsp_c, rsp_err} !== {4'd4, 32'hDEADBEEF, 1'b0}) begin
      miscompares++;
      $display("FAIL divzero got wait=%0d c=%h e=%b exp 4/deadbeef/0", waited, rsp_c, rsp_err);
    end
`endif
    drain();
  endtask

  task automatic test_reset_abort();
    ra[0] = 3; rb[0] = 4; rs[0] = 3'b010;
    req_valid = 2'b01;
    tick();
    req_valid = 2'b00;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({busy, rsp_valid, req_ready, alu_a, alu_b, alu_sel} !== '0) begin
      miscompares++;
      $display("FAIL abort_outputs got busy=%b v=%b rdy=%b alu=%h/%h/%h exp all 0",
               busy, rsp_valid, req_ready, alu_a, alu_b, alu_sel);
    end
    q.delete();
    seen = 0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_rsp got=%b exp=0", rsp_valid); end
    end
    ra[0] = 2; rb[0] = 2; rs[0] = 3'b000;
    ra[1] = 4; rb[1] = 4; rs[1] = 3'b000;
    req_valid = 2'b11;
    #1;
    vectors++;
    if (req_ready !== 2'b01) begin miscompares++; $display("FAIL abort_priority got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b00;
    drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_add();
    test_div_mod();
    test_back_pressure();
    test_div_zero();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
